// File: rtl/pc_gen.sv
// pc_gen: program-counter stage feeding fetch.
// Picks the next pc from three sources: sequential (+PC_STEP), a jump redirect or a
// branch redirect. The pc holds while the hazard unit stalls. A redirect that arrives
// during a stall is captured and then applied when the stall is released.
// Optional feature: when `MISALIGN_TRAP_EN is defined, a misaligned redirect target
// loads TRAP_VECTOR and pulses misalign. When it is not defined, target[1:0] is
// cleared on load and misalign is tied low.
module pc_gen #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] PC_STEP     = 32'd4,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic        redirect_pend,
  output logic        misalign
);

  typedef enum logic [1:0] {RUN, HOLD, HOLD_PEND} state_t;

  state_t      state;
  logic [31:0] pend_target;
  logic        pend_is_branch;

  logic        redir;
  logic [31:0] sel_tgt;
  logic        pend_overtake;
  logic [31:0] ld_tgt;
  logic [31:0] ld_pc;
  logic        ld_mis;

  assign pc_plus4      = pc + PC_STEP;
  assign redirect_pend = (state == HOLD_PEND);

  // Choose the redirect target. The branch wins because it comes from the older
  // instruction. A live branch also displaces a pending jump.
  always_comb begin
    redir         = branch_taken | jump;
    sel_tgt       = branch_taken ? branch_target : jump_target;
    pend_overtake = branch_taken & ~pend_is_branch;
    ld_tgt        = sel_tgt;
    if (state == HOLD_PEND)
      ld_tgt = pend_overtake ? branch_target : pend_target;
  end

  // Apply the alignment policy to whichever target is being loaded.
`ifdef MISALIGN_TRAP_EN
  always_comb begin
    ld_mis = (ld_tgt[1:0] != 2'b00);
    ld_pc  = ld_mis ? TRAP_VECTOR : ld_tgt;
  end
`else
  always_comb begin
    ld_mis = 1'b0;
    ld_pc  = {ld_tgt[31:2], 2'b00};
  end
`endif

  // Redirect/stall FSM, with the pc and its status outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc             <= RESET_PC;
      state          <= RUN;
      pend_target    <= 32'h0;
      pend_is_branch <= 1'b0;
      fetch_valid    <= 1'b0;
      misalign       <= 1'b0;
    end else begin
      fetch_valid <= ~stall;
      misalign    <= 1'b0;
      case (state)
        RUN, HOLD: begin
          if (!stall) begin
            if (redir) begin
              pc       <= ld_pc;
              misalign <= ld_mis;
            end else begin
              pc <= pc_plus4;
            end
            state <= RUN;
          end else if (redir) begin
            pend_target    <= sel_tgt;
            pend_is_branch <= branch_taken;
            state          <= HOLD_PEND;
          end else begin
            state <= HOLD;
          end
        end
        HOLD_PEND: begin
          if (!stall) begin
            pc       <= ld_pc;
            misalign <= ld_mis;
            state    <= RUN;
          end else if (pend_overtake) begin
            pend_target    <= branch_target;
            pend_is_branch <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
